// File: rtl/hash_digest_tx.sv
// Merges a weight beat stream with queued 256-bit reference digests into one AXI-R-style stream.
// Optional beat/digest counters are enabled with `define HASH_TX_CNT_EN.
module hash_digest_tx #(
  parameter int AXI_WIDTH       = 64,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int WEIGHT_ID       = 0,
  parameter int HASH_ID         = 1,
  parameter int HASH_FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [AXI_WIDTH-1:0]                 s_wgt_data,
  input  logic                                 s_wgt_valid,
  input  logic                                 s_wgt_last,
  output logic                                 s_wgt_ready,
  input  logic [255:0]                         s_hash_digest,
  input  logic                                 s_hash_valid,
  output logic                                 s_hash_ready,
  output logic [AXI_WIDTH-1:0]                 m_data,
  output logic [AXI_ID_WIDTH-1:0]              m_id,
  output logic                                 m_valid,
  output logic                                 m_last,
  input  logic                                 m_ready,
`ifdef HASH_TX_CNT_EN
  output logic [31:0]                          wgt_beat_cnt,
  output logic [31:0]                          digest_cnt,
`endif
  output logic [$clog2(HASH_FIFO_DEPTH):0]     fifo_level
);

  localparam int N_BEATS = 256 / AXI_WIDTH;
  localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int PW      = $clog2(HASH_FIFO_DEPTH);
  localparam int LW      = PW + 1;

  typedef enum logic {S_WGT, S_HASH} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           beat_cnt, beat_nxt;
  logic                    mid_block, mid_nxt;
  logic                    loadable;
  logic                    load_en;
  logic [AXI_WIDTH-1:0]    load_data;
  logic [AXI_ID_WIDTH-1:0] load_id;
  logic                    load_last;
  logic                    push, pop;
  logic                    fifo_empty, fifo_full;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [255:0]            fifo_mem [HASH_FIFO_DEPTH];
  logic [255:0]            fifo_head;
  logic [AXI_WIDTH-1:0]    head_word;
  logic                    beat_is_last;

  assign loadable     = !m_valid || m_ready;
  assign fifo_empty   = (fifo_level == '0);
  assign fifo_full    = (fifo_level == LW'(HASH_FIFO_DEPTH));
  assign s_hash_ready = !fifo_full;
  // A push never relies on a same-cycle pop to make room.
  assign push         = s_hash_valid && !fifo_full;
  assign fifo_head    = fifo_mem[rd_ptr];
  assign head_word    = fifo_head[int'(beat_cnt)*AXI_WIDTH +: AXI_WIDTH];
  assign beat_is_last = (beat_cnt == CW'(N_BEATS - 1));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_cnt;
    mid_nxt     = mid_block;
    load_en     = 1'b0;
    load_data   = s_wgt_data;
    load_id     = AXI_ID_WIDTH'(WEIGHT_ID);
    load_last   = s_wgt_last;
    pop         = 1'b0;
    s_wgt_ready = 1'b0;
    case (state)
      S_WGT: begin
        s_wgt_ready = loadable;
        if (s_wgt_valid && loadable) begin
          load_en = 1'b1;
          mid_nxt = !s_wgt_last;
          if (s_wgt_last && (!fifo_empty || push)) state_nxt = S_HASH;
        end else if (!s_wgt_valid && !fifo_empty && loadable && !mid_block) begin
          state_nxt = S_HASH;
        end
      end
      S_HASH: begin
        load_data = head_word;
        load_id   = AXI_ID_WIDTH'(HASH_ID);
        load_last = beat_is_last;
        if (loadable) begin
          load_en = 1'b1;
          if (beat_is_last) begin
            beat_nxt  = '0;
            pop       = 1'b1;
            state_nxt = S_WGT;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = S_WGT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_WGT;
      beat_cnt  <= '0;
      mid_block <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      mid_block <= mid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= '0;
      m_last  <= 1'b0;
    end else if (loadable) begin
      m_valid <= load_en;
      if (load_en) begin
        m_data <= load_data;
        m_id   <= load_id;
        m_last <= load_last;
      end
    end
  end

  // NOTE: digest storage is not reset; the level and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_hash_digest;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef HASH_TX_CNT_EN
  logic slot_is_hash;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_is_hash <= 1'b0;
      wgt_beat_cnt <= '0;
      digest_cnt   <= '0;
    end else begin
      if (loadable && load_en) slot_is_hash <= (state == S_HASH);
      if (m_valid && m_ready && !slot_is_hash)          wgt_beat_cnt <= wgt_beat_cnt + 1'b1;
      if (m_valid && m_ready && slot_is_hash && m_last) digest_cnt   <= digest_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_digest_tx.sv
// Scoreboard bench for hash_digest_tx: expected beats are queued when stimulus is driven
// and compared as each beat is handshaken on the m_* port.
module tb_hash_digest_tx;

  typedef struct packed {
    logic [63:0] data;
    logic [5:0]  id;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [63:0]  s_wgt_data = '0;
  logic         s_wgt_valid = 1'b0;
  logic         s_wgt_last = 1'b0;
  logic         s_wgt_ready;
  logic [255:0] s_hash_digest = '0;
  logic         s_hash_valid = 1'b0;
  logic         s_hash_ready;
  logic [63:0]  m_data;
  logic [5:0]   m_id;
  logic         m_valid;
  logic         m_last;
  logic         m_ready = 1'b1;
  logic [2:0]   fifo_level;
`ifdef HASH_TX_CNT_EN
  logic [31:0]  wgt_beat_cnt;
  logic [31:0]  digest_cnt;
`endif

  int    n_checks = 0;
  int    n_errors = 0;
  int    hs_cnt   = 0;
  beat_t exp_q[$];

  hash_digest_tx dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_wgt_data    (s_wgt_data),
    .s_wgt_valid   (s_wgt_valid),
    .s_wgt_last    (s_wgt_last),
    .s_wgt_ready   (s_wgt_ready),
    .s_hash_digest (s_hash_digest),
    .s_hash_valid  (s_hash_valid),
    .s_hash_ready  (s_hash_ready),
    .m_data        (m_data),
    .m_id          (m_id),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready),
`ifdef HASH_TX_CNT_EN
    .wgt_beat_cnt  (wgt_beat_cnt),
    .digest_cnt    (digest_cnt),
`endif
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_wgt(input logic [63:0] d, input logic l);
    exp_q.push_back('{data: d, id: 6'd0, last: l});
  endtask

  task automatic exp_digest(input logic [255:0] d);
    for (int k = 0; k < 4; k++) exp_q.push_back('{data: d[k*64 +: 64], id: 6'd1, last: (k == 3)});
  endtask

  task automatic send_wgt(input logic [63:0] d, input logic l);
    int   n = 0;
    logic acc;
    s_wgt_data  = d;
    s_wgt_last  = l;
    s_wgt_valid = 1'b1;
    do begin
      @(negedge clk); acc = s_wgt_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    s_wgt_valid = 1'b0;
    if (!acc) check("wgt_accept_timeout", acc, 1'b1);
  endtask

  task automatic push_hash(input logic [255:0] d);
    int   n = 0;
    logic acc;
    s_hash_digest = d;
    s_hash_valid  = 1'b1;
    do begin
      @(negedge clk); acc = s_hash_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    s_hash_valid = 1'b0;
    check("hash_accept", acc, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare, stall stability, and wgt-ready blocking mid-digest.
  beat_t held;
  logic  stalled = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_stable", {m_data, m_id, m_last}, held);
      end
      if (m_valid && m_id == 6'd1 && !m_last) check("wgt_ready_in_hash", s_wgt_ready, 1'b0);
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("spurious_beat", exp_q.size(), 1);
        else check("beat", {m_data, m_id, m_last}, exp_q.pop_front());
      end
      stalled = m_valid && !m_ready;
      held    = '{data: m_data, id: m_id, last: m_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] dg [5];
    logic         pat [4];
    int           base, n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    #12;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_id", m_id, 6'd0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_fifo_level", fifo_level, 3'd0);
    check("rst_hash_ready", s_hash_ready, 1'b1);
    check("rst_wgt_ready", s_wgt_ready, 1'b1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: pass-through with tlast every 8th beat
    for (int i = 0; i < 16; i++) begin
      exp_wgt(64'h1000 + 64'(i), (i % 8) == 7);
      send_wgt(64'h1000 + 64'(i), (i % 8) == 7);
      if (i == 0) begin
        check("latency_valid", m_valid, 1'b1);
        check("latency_data", m_data, 64'h1000);
      end
    end
    wait_drain();
`ifdef HASH_TX_CNT_EN
    check("cnt_wgt", wgt_beat_cnt, 32'd16);
`endif

    // 2: digest pushed alongside a weight block is inserted after the block
    dg[0] = {64'd4, 64'd3, 64'd2, 64'd1};
    for (int i = 0; i < 8; i++) exp_wgt(64'h2000 + 64'(i), i == 7);
    exp_digest(dg[0]);
    fork
      push_hash(dg[0]);
      for (int i = 0; i < 8; i++) send_wgt(64'h2000 + 64'(i), i == 7);
    join
    check("ins_level_pending", fifo_level, 3'd1);
    wait_drain();
    check("ins_level_done", fifo_level, 3'd0);

    // 3: idle-gap insertion of two digests
    dg[1] = {64'hA3A3, 64'hA2A2, 64'hA1A1, 64'hA0A0};
    dg[2] = {64'hB3B3, 64'hB2B2, 64'hB1B1, 64'hB0B0};
    exp_digest(dg[1]);
    exp_digest(dg[2]);
    push_hash(dg[1]);
    push_hash(dg[2]);
    wait_drain();

    // 4: backpressure during a digest
    dg[3] = {64'hC3C3, 64'hC2C2, 64'hC1C1, 64'hC0C0};
    exp_digest(dg[3]);
    push_hash(dg[3]);
    for (int i = 0; i < 16; i++) begin
      m_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_drain();

    // 5: fill the FIFO with no drain
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dg[i] = {64'(i*16+3), 64'(i*16+2), 64'(i*16+1), 64'(i*16)} | {4{64'hD000}};
      exp_digest(dg[i]);
    end
    for (int i = 0; i < 4; i++) push_hash(dg[i]);
    check("full_level", fifo_level, 3'd4);
    check("full_hash_ready", s_hash_ready, 1'b0);
    m_ready = 1'b1;
    push_hash(dg[4]);
    wait_drain();

    // 6: asynchronous reset in the middle of a digest
    dg[0] = {64'hE3E3, 64'hE2E2, 64'hE1E1, 64'hE0E0};
    dg[1] = {64'hF3F3, 64'hF2F2, 64'hF1F1, 64'hF0F0};
    exp_digest(dg[0]);
    exp_digest(dg[1]);
    base = hs_cnt;
    push_hash(dg[0]);
    push_hash(dg[1]);
    n = 0;
    while (hs_cnt < base + 2 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("rst_mid_reach", hs_cnt - base, 2);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", m_valid, 1'b0);
    check("rst_mid_level", fifo_level, 3'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_wgt(64'h6000 + 64'(i), i == 3);
      send_wgt(64'h6000 + 64'(i), i == 3);
    end
    wait_drain();
    check("post_rst_level", fifo_level, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
